// File: rtl/life_pattern_loader.sv
// rtl/life_pattern_loader.sv - loads one of four preset seed patterns into the 8x8 life array
// Holds off generation stepping while a pattern is partially written.
module life_pattern_loader #(
  parameter int WORD_W        = 16,
  parameter int NUM_WORDS     = 4,
  parameter int LOAD_ON_RESET = 0,
  parameter int INIT_PATTERN  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [1:0]        pattern_sel,
  input  logic              step_in,
  output logic              step_out,
  output logic [WORD_W-1:0] vali,
  output logic [1:0]        array_in_selector,
  output logic              write_enb,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(NUM_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [1:0]      pat;
  logic            load_req_q;
  logic            auto_pend;
  logic            start;
  logic [1:0]      start_pat;

  function automatic logic [WORD_W-1:0] rom_word(input logic [1:0] p, input logic [1:0] w);
    logic [15:0] v;
    case ({p, w})
      4'b01_00: v = 16'h2010;
      4'b01_01: v = 16'h7000;
      4'b10_01: v = 16'h001C;
      4'b11_01: v = 16'h0018;
      4'b11_10: v = 16'h1800;
      default:  v = 16'h0000;
    endcase
    return WORD_W'(v);
  endfunction

  // Auto-load takes priority over a coincident request edge.
  always_comb begin
    start     = auto_pend | (load_req & ~load_req_q);
    start_pat = auto_pend ? 2'(INIT_PATTERN) : pattern_sel;
  end

  assign step_out = step_in & ~busy;

  // Word 0 is presented on the start edge so writes land in the four cycles right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      pat               <= '0;
      load_req_q        <= 1'b1;
      auto_pend         <= (LOAD_ON_RESET != 0);
      vali              <= '0;
      array_in_selector <= '0;
      write_enb         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      load_req_q <= load_req;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            pat               <= start_pat;
            auto_pend         <= 1'b0;
            busy              <= 1'b1;
            write_enb         <= 1'b1;
            array_in_selector <= 2'd0;
            vali              <= rom_word(start_pat, 2'd0);
            idx               <= IW'(1);
            state             <= WRITE;
          end
        end
        WRITE: begin
          if (idx == IW'(NUM_WORDS)) begin
            write_enb <= 1'b0;
            done      <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            write_enb         <= 1'b1;
            array_in_selector <= idx[1:0];
            vali              <= rom_word(pat, idx[1:0]);
            idx               <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_pattern_loader.sv
// tb/tb_life_pattern_loader.sv - directed table-driven bench for life_pattern_loader
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_life_pattern_loader;

  logic        clk = 1'b0;
  logic        reset, load_req, step_in;
  logic [1:0]  pattern_sel;
  logic        step_out, write_enb, busy, done;
  logic [15:0] vali;
  logic [1:0]  array_in_selector;

  logic        reset_a, load_req_a, step_in_a;
  logic [1:0]  pattern_sel_a;
  logic        step_out_a, write_enb_a, busy_a, done_a;
  logic [15:0] vali_a;
  logic [1:0]  sel_a;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  life_pattern_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .pattern_sel(pattern_sel),
    .step_in(step_in), .step_out(step_out), .vali(vali),
    .array_in_selector(array_in_selector), .write_enb(write_enb),
    .busy(busy), .done(done)
  );

  life_pattern_loader #(.LOAD_ON_RESET(1), .INIT_PATTERN(2)) dut_auto (
    .clk(clk), .reset(reset_a), .load_req(load_req_a), .pattern_sel(pattern_sel_a),
    .step_in(step_in_a), .step_out(step_out_a), .vali(vali_a),
    .array_in_selector(sel_a), .write_enb(write_enb_a),
    .busy(busy_a), .done(done_a)
  );

  typedef struct {
    logic        lr;
    logic [1:0]  ps;
    logic        si;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] v;
    logic        b;
    logic        d;
    logic        so;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic lr, input logic [1:0] ps, input logic si,
                         input logic we, input logic [1:0] sel, input logic [15:0] v,
                         input logic b, input logic d, input logic so);
    vecs[i] = '{lr, ps, si, we, sel, v, b, d, so};
  endtask

  int writes;
  int dones;
  logic [15:0] exp_p1[4];

  initial begin
    exp_p1[0] = 16'h2010; exp_p1[1] = 16'h7000; exp_p1[2] = 16'h0000; exp_p1[3] = 16'h0000;

    //         lr ps  si  we sel  vali      b  d  so
    set_vec( 0, 0, 1, 1,  0, 0, 16'h0000, 0, 0, 1);
    set_vec( 1, 1, 1, 1,  1, 0, 16'h2010, 1, 0, 0);
    set_vec( 2, 0, 1, 1,  1, 1, 16'h7000, 1, 0, 0);
    set_vec( 3, 1, 2, 1,  1, 2, 16'h0000, 1, 0, 0);
    set_vec( 4, 1, 2, 1,  1, 3, 16'h0000, 1, 0, 0);
    set_vec( 5, 1, 2, 1,  0, 0, 16'h0000, 1, 1, 0);
    set_vec( 6, 1, 2, 1,  0, 0, 16'h0000, 0, 0, 1);
    set_vec( 7, 1, 3, 1,  0, 0, 16'h0000, 0, 0, 1);
    set_vec( 8, 0, 3, 1,  0, 0, 16'h0000, 0, 0, 1);
    set_vec( 9, 1, 3, 1,  1, 0, 16'h0000, 1, 0, 0);
    set_vec(10, 1, 0, 1,  1, 1, 16'h0018, 1, 0, 0);
    set_vec(11, 1, 0, 1,  1, 2, 16'h1800, 1, 0, 0);
    set_vec(12, 1, 0, 1,  1, 3, 16'h0000, 1, 0, 0);
    set_vec(13, 0, 0, 1,  0, 0, 16'h0000, 1, 1, 0);
    set_vec(14, 0, 0, 0,  0, 0, 16'h0000, 0, 0, 0);
    set_vec(15, 1, 2, 1,  1, 0, 16'h0000, 1, 0, 0);
    set_vec(16, 1, 2, 1,  1, 1, 16'h001C, 1, 0, 0);
    set_vec(17, 1, 2, 1,  1, 2, 16'h0000, 1, 0, 0);
    set_vec(18, 1, 2, 1,  1, 3, 16'h0000, 1, 0, 0);
    set_vec(19, 1, 2, 1,  0, 0, 16'h0000, 1, 1, 0);
    set_vec(20, 1, 2, 1,  0, 0, 16'h0000, 0, 0, 1);

    reset = 1'b1; load_req = 1'b1; pattern_sel = 2'd0; step_in = 1'b0;
    reset_a = 1'b1; load_req_a = 1'b0; pattern_sel_a = 2'd0; step_in_a = 1'b0;
    repeat (3) tick();

    // Request held high through reset must not start a load.
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (write_enb || busy || done || vali != 0 || array_in_selector != 0) begin
        check("reset_hold_outputs", {11'd0, write_enb, busy, done, array_in_selector != 0, vali != 0}, 16'h0);
      end
    end
    check("reset_hold_we", {15'd0, write_enb}, 16'h0);
    check("reset_hold_busy", {15'd0, busy}, 16'h0);
    check("reset_hold_vali", vali, 16'h0);

    for (int i = 0; i < 21; i++) begin
      load_req = vecs[i].lr; pattern_sel = vecs[i].ps; step_in = vecs[i].si;
      tick();
      check($sformatf("v%0d_write_enb", i), {15'd0, write_enb}, {15'd0, vecs[i].we});
      check($sformatf("v%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].b});
      check($sformatf("v%0d_done", i), {15'd0, done}, {15'd0, vecs[i].d});
      check($sformatf("v%0d_step_out", i), {15'd0, step_out}, {15'd0, vecs[i].so});
      if (vecs[i].we) begin
        check($sformatf("v%0d_selector", i), {14'd0, array_in_selector}, {14'd0, vecs[i].sel});
        check($sformatf("v%0d_vali", i), vali, vecs[i].v);
      end
    end

    // Reset two cycles into a load aborts it without a done pulse.
    load_req = 1'b0; step_in = 1'b0; tick();
    load_req = 1'b1; pattern_sel = 2'd1; tick();
    check("abort_start_we", {15'd0, write_enb}, 16'h1);
    tick();
    reset = 1'b1; tick();
    check("abort_we_low", {15'd0, write_enb}, 16'h0);
    check("abort_busy_low", {15'd0, busy}, 16'h0);
    reset = 1'b0;
    dones = 0; writes = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) dones++;
      if (write_enb) writes++;
    end
    check("abort_no_done", 16'(dones), 16'h0);
    check("abort_no_reload", 16'(writes), 16'h0);

    load_req = 1'b0; tick();
    load_req = 1'b1; pattern_sel = 2'd1; tick();
    dones = 0; writes = 0;
    for (int c = 0; c < 7; c++) begin
      if (write_enb) begin
        if (writes < 4) begin
          check($sformatf("reload_sel%0d", writes), {14'd0, array_in_selector}, 16'(writes));
          check($sformatf("reload_vali%0d", writes), vali, exp_p1[writes]);
        end
        writes++;
      end
      if (done) dones++;
      tick();
    end
    check("reload_writes", 16'(writes), 16'd4);
    check("reload_dones", 16'(dones), 16'd1);

    // Auto-load instance: starts on the first cycle after reset deasserts.
    reset_a = 1'b0; step_in_a = 1'b1;
    tick();
    check("auto_we0", {15'd0, write_enb_a}, 16'h1);
    check("auto_sel0", {14'd0, sel_a}, 16'h0);
    check("auto_step_out", {15'd0, step_out_a}, 16'h0);
    tick();
    check("auto_sel1", {14'd0, sel_a}, 16'h1);
    check("auto_vali1", vali_a, 16'h001C);
    tick(); tick();
    check("auto_sel3", {14'd0, sel_a}, 16'h3);
    tick();
    check("auto_done", {15'd0, done_a}, 16'h1);
    check("auto_we_off", {15'd0, write_enb_a}, 16'h0);
    tick();
    check("auto_idle_busy", {15'd0, busy_a}, 16'h0);
    check("auto_idle_done", {15'd0, done_a}, 16'h0);
    tick();
    check("auto_once", {15'd0, write_enb_a}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/life_pattern_loader.md
Name: life_pattern_loader

Overview:
- Write-side companion to the 8x8 life array. It drives the array's write port (vali, write_enb and the word selector) to load one of four preset 64-bit seed patterns from an internal ROM.
- The display reads the array through the valo port; this block writes it through vali.
- It sits between the board controls and life_array_8x8. It also gates the generation step so the array never advances while a pattern is half-loaded.

Parameters:
- WORD_W, 16, width of one array word (two 8-cell rows: bits 15:8 = even row, bits 7:0 = odd row).
- NUM_WORDS, 4, words per 8x8 pattern; word k holds rows 2k and 2k+1.
- LOAD_ON_RESET, 0, when 1 the block automatically loads INIT_PATTERN once after reset deasserts.
- INIT_PATTERN, 0, pattern index used by the auto-load.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_req  input  1  load request; only its rising edge starts a load.
- pattern_sel  input  2  pattern index, sampled on the accepted edge.
- step_in  input  1  raw generation-step enable from the board.
- step_out  output  1  step_in & ~busy, to the life array step input.
- vali  output  WORD_W  word data to the array.
- array_in_selector  output  2  word index being written.
- write_enb  output  1  array write strobe, one word per cycle.
- busy  output  1  high while a load is in progress (WRITE or DONE state).
- done  output  1  one-cycle pulse when a load completes.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - state = IDLE, idx = 0.
  - vali = 0, array_in_selector = 0, write_enb = 0, busy = 0, done = 0.
  - The load_req history register resets to 1, so a request held through reset does not trigger a load.
  - The auto-load pending flag resets to LOAD_ON_RESET.
- All outputs except step_out are registered. step_out is combinational from step_in and the busy register.
- Pattern ROM, words 0..3:
  - Pattern 0, clear: 0000 0000 0000 0000.
  - Pattern 1, glider: 2010 7000 0000 0000.
  - Pattern 2, blinker: 0000 001C 0000 0000.
  - Pattern 3, block: 0000 0018 1800 0000.
- State machine: IDLE -> WRITE -> DONE -> IDLE.
- IDLE:
  - Start condition: load_req & ~load_req_q, or the auto-load pending flag is set.
  - On start: latch the pattern index (pattern_sel, or INIT_PATTERN for an auto-load), clear the auto-load flag, set busy, set idx = 0, go to WRITE.
  - If an auto-load and an edge coincide, the auto-load wins.
- WRITE:
  - Each cycle: write_enb = 1, array_in_selector = idx, vali = ROM[pat][idx].
  - idx increments; after idx = 3 is presented, go to DONE.
  - Exactly 4 write cycles, idx ascending 0..3.
- DONE:
  - write_enb = 0, done = 1 for one cycle, busy still 1. Next state is IDLE with busy = 0.
- Latency:
  - Edge sampled at cycle N.
  - Writes occur in cycles N+1..N+4.
  - done is high in cycle N+5.
  - busy is high from N+1 through N+5.
- load_req edges arriving while busy are ignored, not queued. A new edge is needed after returning to IDLE.
- A load_req held high produces only one load.
- Changing pattern_sel mid-load has no effect on the words being written.
- Reset mid-load aborts the load:
  - write_enb goes low the following cycle.
  - No done pulse is produced.
  - Words already written stay in the array.
- Back-to-back loads: an edge seen in the first IDLE cycle after DONE is accepted. The minimum period between loads is 6 cycles.
- step_out is forced low whenever busy = 1, regardless of step_in.

Test Plan:
- Reset release with load_req held at 1 and LOAD_ON_RESET = 0 -> no write_enb for 20 cycles; all outputs stay 0.
- load_req 0->1 with pattern_sel = 1 -> in cycles N+1..N+4, (selector, vali) = (0,2010), (1,7000), (2,0000), (3,0000) with write_enb = 1; done pulses at N+5; busy = 0 at N+6.
- step_in held at 1 during a pattern-3 load -> step_out = 0 for exactly 5 cycles (N+1..N+5), 1 otherwise; the words written are 0000, 0018, 1800, 0000.
- Second load_req edge at N+2, and pattern_sel changed to 2 at N+2 -> the edge is ignored and the pattern-1 words are written unchanged; only one done pulse.
- reset asserted at N+2 of a load -> write_enb = 0 from N+3 onward, no done pulse; the next edge after reset performs a full 4-word load.
- LOAD_ON_RESET = 1, INIT_PATTERN = 2 -> the first cycle after reset deasserts starts the load; 001C is written at selector 1; done pulses 5 cycles after the start.
